center_sched: RTL and testbench

Round-robin scheduler that shares one polygon centroid/area engine among `NUM_REQ` cluster units in the K-means datapath. It grants one requester at a time and forwards that requester's vertex stream to the engine. It then waits for the engine to finish and returns the area and centroid tagged with the requester ID. Bad vertex counts and a hung engine are reported as error results instead of stalling the pipeline.

---
 rtl/center_sched.sv | 267 ++++++++++++++++++++++++++
 tb/tb_center_sched.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/center_sched.sv
// center_sched: round-robin scheduler sharing one polygon centroid/area
// engine between NUM_REQ cluster units, with bad-count and hang detection.
//
// Ports:
//   Sched_clk, Sched_rst      clock, synchronous active-high reset
//   req, req_qty              per-unit job request (level) and vertex count
//   pt_valid, pt_x, pt_y      per-unit vertex streams
//   pt_ready                  per-unit vertex accept (granted bit only)
//   gnt                       one-hot grant, held for the whole job
//   eng_start, eng_qty        job start pulse and vertex count to engine
//   eng_valid, eng_x, eng_y   vertex stream to engine
//   eng_ready                 engine accepts vertex
//   eng_done, eng_area/cx/cy  engine result pulse and data
//   res_valid, res_err        result pulse and error flag
//   res_id, res_area/cx/cy    result tag and data
module center_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MAX_PTS = 9,
    parameter int TIMEOUT = 1023
) (
    input  logic                   Sched_clk,
    input  logic                   Sched_rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*7-1:0]   req_qty,
    input  logic [NUM_REQ-1:0]     pt_valid,
    input  logic [NUM_REQ*9-1:0]   pt_x,
    input  logic [NUM_REQ*9-1:0]   pt_y,
    output logic [NUM_REQ-1:0]     pt_ready,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   eng_start,
    output logic [6:0]             eng_qty,
    output logic                   eng_valid,
    output logic [8:0]             eng_x,
    output logic [8:0]             eng_y,
    input  logic                   eng_ready,
    input  logic                   eng_done,
    input  logic [31:0]            eng_area,
    input  logic [8:0]             eng_cx,
    input  logic [8:0]             eng_cy,
    output logic                   res_valid,
    output logic                   res_err,
    output logic [ID_W-1:0]        res_id,
    output logic [31:0]            res_area,
    output logic [8:0]             res_cx,
    output logic [8:0]             res_cy
);

    localparam int CW = ID_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]      cur_id_q, cur_id_d;
    logic [6:0]           qty_q, qty_d;
    logic [6:0]           pt_cnt_q, pt_cnt_d;
    logic [9:0]           wd_cnt_q, wd_cnt_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_err_q, res_err_d;
    logic [ID_W-1:0]      res_id_q, res_id_d;
    logic [31:0]          res_area_q, res_area_d;
    logic [8:0]           res_cx_q, res_cx_d;
    logic [8:0]           res_cy_q, res_cy_d;

    logic                 pick_vld;
    logic [ID_W-1:0]      pick_id;
    logic [6:0]           pick_qty;
    logic                 qty_bad;
    logic [CW-1:0]        cand;

    logic                 sel_valid;
    logic [8:0]           sel_x;
    logic [8:0]           sel_y;
    logic                 xfer;

    // Rotating priority search: first set req bit at or above rr_ptr,
    // wrapping at NUM_REQ (which need not be a power of two).
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!pick_vld && req[cand[ID_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        pick_qty = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == ID_W'(i)) begin
                pick_qty = req_qty[7*i +: 7];
            end
        end
    end

    assign qty_bad = (pick_qty == 7'd0) || (pick_qty > 7'(MAX_PTS));

    // Granted-slice mux; gnt_q is one-hot or zero.
    always_comb begin
        sel_valid = 1'b0;
        sel_x     = '0;
        sel_y     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                sel_valid = pt_valid[i];
                sel_x     = pt_x[9*i +: 9];
                sel_y     = pt_y[9*i +: 9];
            end
        end
    end

    // State register
    always_ff @(posedge Sched_clk) begin
        if (Sched_rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            cur_id_q    <= '0;
            qty_q       <= '0;
            pt_cnt_q    <= '0;
            wd_cnt_q    <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_id_q    <= '0;
            res_area_q  <= '0;
            res_cx_q    <= '0;
            res_cy_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            cur_id_q    <= cur_id_d;
            qty_q       <= qty_d;
            pt_cnt_q    <= pt_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
            res_id_q    <= res_id_d;
            res_area_q  <= res_area_d;
            res_cx_q    <= res_cx_d;
            res_cy_q    <= res_cy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        cur_id_d    = cur_id_q;
        qty_d       = qty_q;
        pt_cnt_d    = pt_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        res_valid_d = 1'b0;
        res_err_d   = res_err_q;
        res_id_d    = res_id_q;
        res_area_d  = res_area_q;
        res_cx_d    = res_cx_q;
        res_cy_d    = res_cy_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_d    = NUM_REQ'(1) << pick_id;
                    cur_id_d = pick_id;
                    qty_d    = pick_qty;
                    if (qty_bad) begin
                        state_d     = S_DONE;
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b1;
                        res_id_d    = pick_id;
                        res_area_d  = '0;
                        res_cx_d    = '0;
                        res_cy_d    = '0;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                pt_cnt_d = '0;
                state_d  = S_FEED;
            end
            S_FEED: begin
                if (xfer) begin
                    pt_cnt_d = pt_cnt_q + 7'd1;
                    if (pt_cnt_q == qty_q - 7'd1) begin
                        wd_cnt_d = '0;
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A result arriving on the last watchdog cycle still wins.
                if (eng_done) begin
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b0;
                    res_id_d    = cur_id_q;
                    res_area_d  = eng_area;
                    res_cx_d    = eng_cx;
                    res_cy_d    = eng_cy;
                end else if (wd_cnt_q == 10'(TIMEOUT)) begin
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b1;
                    res_id_d    = cur_id_q;
                    res_area_d  = '0;
                    res_cx_d    = '0;
                    res_cy_d    = '0;
                end else begin
                    wd_cnt_d = wd_cnt_q + 10'd1;
                end
            end
            S_DONE: begin
                gnt_d    = '0;
                rr_ptr_d = (cur_id_q == ID_W'(NUM_REQ - 1)) ?
                           '0 : cur_id_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Output decode
    always_comb begin
        eng_start = (state_q == S_START);
        eng_valid = 1'b0;
        eng_x     = '0;
        eng_y     = '0;
        pt_ready  = '0;
        if (state_q == S_FEED) begin
            eng_valid = sel_valid;
            eng_x     = sel_x;
            eng_y     = sel_y;
            pt_ready  = eng_ready ? gnt_q : '0;
        end
    end

    assign xfer      = eng_valid && eng_ready;
    assign gnt       = gnt_q;
    assign eng_qty   = qty_q;
    assign res_valid = res_valid_q;
    assign res_err   = res_err_q;
    assign res_id    = res_id_q;
    assign res_area  = res_area_q;
    assign res_cx    = res_cx_q;
    assign res_cy    = res_cy_q;

endmodule

// File: tb/tb_center_sched.sv
// tb_center_sched: scoreboard bench for center_sched with a requester
// model, an engine model and directed job sequences.
module tb_center_sched;

    localparam int NR = 4;

    logic            Sched_clk = 1'b0;
    logic            Sched_rst;
    logic [NR-1:0]   req;
    logic [NR*7-1:0] req_qty;
    logic [NR-1:0]   pt_valid;
    logic [NR*9-1:0] pt_x;
    logic [NR*9-1:0] pt_y;
    logic [NR-1:0]   pt_ready;
    logic [NR-1:0]   gnt;
    logic            eng_start;
    logic [6:0]      eng_qty;
    logic            eng_valid;
    logic [8:0]      eng_x;
    logic [8:0]      eng_y;
    logic            eng_ready;
    logic            eng_done;
    logic [31:0]     eng_area;
    logic [8:0]      eng_cx;
    logic [8:0]      eng_cy;
    logic            res_valid;
    logic            res_err;
    logic [1:0]      res_id;
    logic [31:0]     res_area;
    logic [8:0]      res_cx;
    logic [8:0]      res_cy;

    center_sched dut (
        .Sched_clk (Sched_clk),
        .Sched_rst (Sched_rst),
        .req       (req),
        .req_qty   (req_qty),
        .pt_valid  (pt_valid),
        .pt_x      (pt_x),
        .pt_y      (pt_y),
        .pt_ready  (pt_ready),
        .gnt       (gnt),
        .eng_start (eng_start),
        .eng_qty   (eng_qty),
        .eng_valid (eng_valid),
        .eng_x     (eng_x),
        .eng_y     (eng_y),
        .eng_ready (eng_ready),
        .eng_done  (eng_done),
        .eng_area  (eng_area),
        .eng_cx    (eng_cx),
        .eng_cy    (eng_cy),
        .res_valid (res_valid),
        .res_err   (res_err),
        .res_id    (res_id),
        .res_area  (res_area),
        .res_cx    (res_cx),
        .res_cy    (res_cy)
    );

    always #5 Sched_clk = ~Sched_clk;

    typedef struct packed {
        logic [3:0]  g;
        logic [1:0]  id;
        logic        err;
        logic [31:0] area;
        logic [8:0]  cx;
        logic [8:0]  cy;
    } res_t;

    typedef struct packed {
        logic [1:0] id;
        logic [8:0] x;
        logic [8:0] y;
    } vtx_t;

    typedef struct {
        int          qty;
        int          lat;
        logic [31:0] area;
        logic [8:0]  cx;
        logic [8:0]  cy;
    } eng_t;

    res_t exp_r[$];
    vtx_t exp_v[$];
    eng_t exp_e[$];

    int   n_chk = 0;
    int   n_pass = 0;
    int   n_start = 0;
    int   viol = 0;
    logic rdy_mode = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [8:0] px(input int u, input int k);
        return 9'(u * 32 + k + 1);
    endfunction

    function automatic logic [8:0] py(input int u, input int k);
        return 9'(300 - u * 16 - k);
    endfunction

    // Requester + engine model, and the scoreboard monitor.
    int   idx[NR];
    eng_t cur;
    logic e_act = 1'b0;
    int   e_got = 0;
    int   cd = 0;
    logic cd_act = 1'b0;

    initial begin : model
        logic          s_rst;
        logic          s_start;
        logic [NR-1:0] s_gnt;
        int            s_fire;
        vtx_t          v;
        res_t          r;
        eng_ready = 1'b0;
        eng_done  = 1'b0;
        eng_area  = '0;
        eng_cx    = '0;
        eng_cy    = '0;
        pt_valid  = '1;
        for (int i = 0; i < NR; i++) begin
            idx[i] = 0;
            pt_x[9*i +: 9] = px(i, 0);
            pt_y[9*i +: 9] = py(i, 0);
        end
        forever begin
            @(negedge Sched_clk);
            s_rst   = Sched_rst;
            s_start = eng_start;
            s_gnt   = gnt;
            s_fire  = -1;
            for (int i = 0; i < NR; i++)
                if (pt_ready[i] && pt_valid[i]) s_fire = i;
            if ((pt_ready & ~gnt) != 0 || (pt_ready != 0 && !eng_ready))
                viol++;
            if (eng_start) begin
                n_start++;
                chk("start_expected", 64'(exp_e.size() != 0), 64'd1);
                if (exp_e.size() != 0) begin
                    cur = exp_e.pop_front();
                    chk("eng_qty", 64'(eng_qty), 64'(cur.qty));
                    e_act = 1'b1;
                    e_got = 0;
                end
            end
            if (eng_valid && eng_ready) begin
                chk("vtx_expected", 64'(exp_v.size() != 0), 64'd1);
                if (exp_v.size() != 0) begin
                    v = exp_v.pop_front();
                    chk("vertex", 64'({pt_ready, eng_x, eng_y}),
                        64'({4'(1 << v.id), v.x, v.y}));
                end
                if (e_act) begin
                    e_got++;
                    if (e_got == cur.qty) begin
                        e_act = 1'b0;
                        if (cur.lat > 0) begin
                            cd     = cur.lat - 1;
                            cd_act = 1'b1;
                        end
                    end
                end
            end
            if (res_valid) begin
                chk("res_expected", 64'(exp_r.size() != 0), 64'd1);
                if (exp_r.size() != 0) begin
                    r = exp_r.pop_front();
                    chk("result", 64'({gnt, res_id, res_err, res_area,
                                       res_cx, res_cy}), 64'(r));
                end
            end
            @(posedge Sched_clk);
            #1;
            eng_done = 1'b0;
            eng_area = '0;
            eng_cx   = '0;
            eng_cy   = '0;
            if (s_rst) begin
                e_act  = 1'b0;
                cd_act = 1'b0;
            end else if (cd_act) begin
                if (cd == 0) begin
                    eng_done = 1'b1;
                    eng_area = cur.area;
                    eng_cx   = cur.cx;
                    eng_cy   = cur.cy;
                    cd_act   = 1'b0;
                end else begin
                    cd--;
                end
            end
            if (s_start)
                for (int i = 0; i < NR; i++)
                    if (s_gnt[i]) idx[i] = 0;
            if (s_fire >= 0) idx[s_fire]++;
            eng_ready = rdy_mode ? ~eng_ready : 1'b1;
            for (int i = 0; i < NR; i++) begin
                pt_x[9*i +: 9] = px(i, idx[i]);
                pt_y[9*i +: 9] = py(i, idx[i]);
            end
        end
    end

    function automatic res_t mk_res(input int u, input logic err,
                                    input logic [31:0] a,
                                    input logic [8:0] cx,
                                    input logic [8:0] cy);
        res_t r;
        r.g    = 4'(1 << u);
        r.id   = 2'(u);
        r.err  = err;
        r.area = a;
        r.cx   = cx;
        r.cy   = cy;
        return r;
    endfunction

    // lat < 0: engine never answers, a timeout error is expected.
    task automatic push_job(input int u, input int q, input int lat,
                            input logic [31:0] a, input logic [8:0] cx,
                            input logic [8:0] cy);
        eng_t e;
        for (int k = 0; k < q; k++)
            exp_v.push_back({2'(u), px(u, k), py(u, k)});
        e.qty  = q;
        e.lat  = lat;
        e.area = a;
        e.cx   = cx;
        e.cy   = cy;
        exp_e.push_back(e);
        if (lat < 0) exp_r.push_back(mk_res(u, 1'b1, 0, 0, 0));
        else exp_r.push_back(mk_res(u, 1'b0, a, cx, cy));
    endtask

    task automatic set_qty(input int u, input int q);
        req_qty[7*u +: 7] = 7'(q);
    endtask

    task automatic wait_gnt(input logic [3:0] want, input int budget);
        int c = 0;
        @(negedge Sched_clk);
        while (gnt !== want && c < budget) begin
            @(negedge Sched_clk);
            c++;
        end
        chk("grant", 64'(gnt), 64'(want));
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((exp_r.size() != 0 || exp_v.size() != 0) && c < budget) begin
            @(negedge Sched_clk);
            c++;
        end
        chk("drain", 64'(exp_r.size() + exp_v.size()), 64'd0);
        repeat (3) @(negedge Sched_clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, 64'({gnt, pt_ready, eng_start, eng_valid,
                               eng_qty, eng_x, eng_y}), 64'd0);
        chk({nm, "_res"}, 64'({res_valid, res_err, res_id, res_area,
                               res_cx, res_cy}), 64'd0);
    endtask

    initial begin : stim
        logic [3:0] prev;
        int         ng;
        int         c;
        Sched_rst = 1'b1;
        req       = '0;
        req_qty   = '0;
        repeat (3) @(negedge Sched_clk);
        chk_zero("reset");
        Sched_rst = 1'b0;
        @(negedge Sched_clk);

        // Round-robin: 0,1,2,3 then 0 again.
        for (int u = 0; u < NR; u++) set_qty(u, 2);
        for (int j = 0; j < 5; j++)
            push_job(j % NR, 2, 1, 32'(100 + j), 9'(j), 9'(10 + j));
        req  = 4'b1111;
        prev = '0;
        ng   = 0;
        c    = 0;
        while (ng < 5 && c < 300) begin
            @(negedge Sched_clk);
            if (prev == 0 && gnt != 0) ng++;
            prev = gnt;
            c++;
        end
        req = '0;
        chk("rr_grants", 64'(ng), 64'd5);
        drain(100);

        // Single job on unit 2.
        set_qty(2, 4);
        push_job(2, 4, 5, 32'h64, 9'h12, 9'h34);
        req[2] = 1'b1;
        wait_gnt(4'b0100, 20);
        req = '0;
        drain(100);

        // Backpressure, maximum count, unit 3.
        rdy_mode = 1'b1;
        set_qty(3, 9);
        push_job(3, 9, 3, 32'hDEAD_BEEF, 9'h1AB, 9'h0CD);
        req[3] = 1'b1;
        wait_gnt(4'b1000, 20);
        req = '0;
        drain(200);
        rdy_mode = 1'b0;

        // Bad counts: 0 on unit 0, 10 on unit 1.
        set_qty(0, 0);
        exp_r.push_back(mk_res(0, 1'b1, 0, 0, 0));
        req[0] = 1'b1;
        wait_gnt(4'b0001, 20);
        req = '0;
        drain(20);
        set_qty(1, 10);
        exp_r.push_back(mk_res(1, 1'b1, 0, 0, 0));
        req[1] = 1'b1;
        wait_gnt(4'b0010, 20);
        req = '0;
        drain(20);

        // Timeout on unit 2, then unit 3 is served.
        set_qty(2, 3);
        set_qty(3, 2);
        push_job(2, 3, -1, 0, 0, 0);
        push_job(3, 2, 2, 32'h0001_2345, 9'h055, 9'h0AA);
        req = 4'b1100;
        wait_gnt(4'b0100, 20);
        req = 4'b1000;
        wait_gnt(4'b1000, 1200);
        req = '0;
        drain(100);

        // Reset after 2 of 5 vertices on unit 1.
        set_qty(1, 5);
        set_qty(3, 3);
        for (int k = 0; k < 5; k++)
            exp_v.push_back({2'd1, px(1, k), py(1, k)});
        cur.qty = 0;
        exp_e.push_back('{5, 2, 32'h77, 9'h7, 9'h7});
        req[1] = 1'b1;
        wait_gnt(4'b0010, 20);
        req = '0;
        ng = 0;
        c  = 0;
        while (ng < 2 && c < 50) begin
            @(negedge Sched_clk);
            if (eng_valid && eng_ready) ng++;
            c++;
        end
        chk("pre_reset_xfers", 64'(ng), 64'd2);
        @(negedge Sched_clk);
        Sched_rst = 1'b1;
        @(negedge Sched_clk);
        Sched_rst = 1'b0;
        chk_zero("mid_reset");
        exp_v.delete();
        exp_e.delete();
        push_job(1, 5, 2, 32'h0000_0ABC, 9'h101, 9'h0F0);
        req = 4'b1010;
        wait_gnt(4'b0010, 20);
        req = '0;
        drain(100);

        chk("eng_start_count", 64'(n_start), 64'd11);
        chk("pt_ready_violations", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
